// File: rtl/mem_arbiter_pkg.sv
// rtl/mem_arbiter_pkg.sv - shared state encoding and sizing helper for the memory arbiter
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } arb_state_t;

    // Width able to hold values 0..n-1, never narrower than one bit
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mem_arbiter_rr_pick.sv
// rtl/mem_arbiter_rr_pick.sv - combinational round-robin selector: first requester at index >= ptr, wrapping
module mem_arbiter_rr_pick
    import mem_arbiter_pkg::*;
#(
    parameter  int NMASTERS = 2,
    localparam int IW       = idx_width(NMASTERS)
) (
    input  logic [NMASTERS-1:0] i_req,
    input  logic [IW-1:0]       i_ptr,
    output logic [IW-1:0]       o_winner,
    output logic                o_any
);

    logic [2*NMASTERS-1:0] w_dbl;
    logic [NMASTERS-1:0]   w_rot;
    logic [IW:0]           w_sum;

    // Rotate so bit 0 is the requester at ptr; the doubled copy supplies the wrap
    assign w_dbl = {i_req, i_req} >> i_ptr;
    assign w_rot = w_dbl[NMASTERS-1:0];
    assign o_any = |i_req;

    // Scan downward so the lowest rotated offset is the last (winning) assignment
    always_comb begin
        o_winner = '0;
        w_sum    = '0;
        for (int k = NMASTERS - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                w_sum = {1'b0, i_ptr} + (IW + 1)'(k);
                if (w_sum >= (IW + 1)'(NMASTERS)) begin
                    w_sum = w_sum - (IW + 1)'(NMASTERS);
                end
                o_winner = w_sum[IW-1:0];
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin arbiter sharing one single-port memory between NMASTERS requesters
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int NMASTERS = 2,
    parameter int AW       = 32,
    parameter int DW       = 32,
    parameter int LATENCY  = 1
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [NMASTERS-1:0]    m_req,
    input  logic [NMASTERS-1:0]    m_rw,
    input  logic [NMASTERS*AW-1:0] m_addr,
    input  logic [NMASTERS*DW-1:0] m_wdata,
    output logic [NMASTERS-1:0]    m_ack,
    output logic [NMASTERS-1:0]    m_wait,
    output logic [DW-1:0]          m_rdata,
    output logic                   s_strobe,
    output logic                   s_rw,
    output logic [AW-1:0]          s_addr,
    output logic [DW-1:0]          s_wdata,
    input  logic [DW-1:0]          s_rdata
);

    localparam int IW   = idx_width(NMASTERS);
    localparam int CW   = idx_width(LATENCY);
    localparam int NPAD = 1 << IW;

    if (LATENCY < 1) begin : g_bad_latency
        $error("mem_arbiter: LATENCY must be at least 1");
    end

    arb_state_t            r_state;
    logic [IW-1:0]         r_ptr;
    logic [IW-1:0]         r_grant;
    logic [NMASTERS-1:0]   r_ack;
    logic                  r_strobe;
    logic                  r_rw;
    logic [AW-1:0]         r_addr;
    logic [DW-1:0]         r_wdata;
    logic [DW-1:0]         r_rdata;
    logic [CW-1:0]         r_cnt;

    logic [IW-1:0]         w_winner;
    logic                  w_any;
    logic [IW-1:0]         w_ptr_next;
    logic [NMASTERS-1:0]   w_grant_onehot;
    logic [NPAD-1:0]       w_rw_pad;
    logic [AW-1:0]         w_addr_arr  [NPAD];
    logic [DW-1:0]         w_wdata_arr [NPAD];

    // Pad the per-master views to a power of two so any winner index is in range
    assign w_rw_pad = NPAD'(m_rw);
    for (genvar g = 0; g < NPAD; g++) begin : g_unpack
        if (g < NMASTERS) begin : g_live
            assign w_addr_arr[g]  = m_addr[g*AW +: AW];
            assign w_wdata_arr[g] = m_wdata[g*DW +: DW];
        end else begin : g_pad
            assign w_addr_arr[g]  = '0;
            assign w_wdata_arr[g] = '0;
        end
    end

    mem_arbiter_rr_pick #(
        .NMASTERS (NMASTERS)
    ) u_rr_pick (
        .i_req    (m_req),
        .i_ptr    (r_ptr),
        .o_winner (w_winner),
        .o_any    (w_any)
    );

    // Wrap by compare so non-power-of-two master counts return to 0
    assign w_ptr_next     = (r_grant == IW'(NMASTERS - 1)) ? '0 : r_grant + 1'b1;
    assign w_grant_onehot = NMASTERS'(1) << r_grant;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state  <= ST_IDLE;
            r_ptr    <= '0;
            r_grant  <= '0;
            r_ack    <= '0;
            r_strobe <= 1'b0;
            r_rw     <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_rdata  <= '0;
            r_cnt    <= '0;
        end else begin
            r_ack    <= '0;
            r_strobe <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_grant  <= w_winner;
                        r_rw     <= w_rw_pad[w_winner];
                        r_addr   <= w_addr_arr[w_winner];
                        r_wdata  <= w_wdata_arr[w_winner];
                        r_strobe <= 1'b1;
                        r_state  <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    r_cnt   <= CW'(LATENCY - 1);
                    r_state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (r_cnt == '0) begin
                        r_rdata <= s_rdata;
                        r_ack   <= w_grant_onehot;
                        r_ptr   <= w_ptr_next;
                        r_state <= ST_RESP;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                ST_RESP: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign m_ack    = r_ack;
    assign m_wait   = m_req & ~r_ack;
    assign m_rdata  = r_rdata;
    assign s_strobe = r_strobe;
    assign s_rw     = r_rw;
    assign s_addr   = r_addr;
    assign s_wdata  = r_wdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - randomized self-checking bench for mem_arbiter against a transaction-level model
module tb_mem_arbiter;

    localparam int N  = 3;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int L  = 3;

    logic            clk = 1'b0;
    logic            reset_n = 1'b0;
    logic [N-1:0]    m_req = '0;
    logic [N-1:0]    m_rw = '0;
    logic [N*AW-1:0] m_addr = '0;
    logic [N*DW-1:0] m_wdata = '0;
    logic [N-1:0]    m_ack;
    logic [N-1:0]    m_wait;
    logic [DW-1:0]   m_rdata;
    logic            s_strobe;
    logic            s_rw;
    logic [AW-1:0]   s_addr;
    logic [DW-1:0]   s_wdata;
    logic [DW-1:0]   s_rdata = '0;

    mem_arbiter #(
        .NMASTERS (N),
        .AW       (AW),
        .DW       (DW),
        .LATENCY  (L)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .m_req    (m_req),
        .m_rw     (m_rw),
        .m_addr   (m_addr),
        .m_wdata  (m_wdata),
        .m_ack    (m_ack),
        .m_wait   (m_wait),
        .m_rdata  (m_rdata),
        .s_strobe (s_strobe),
        .s_rw     (s_rw),
        .s_addr   (s_addr),
        .s_wdata  (s_wdata),
        .s_rdata  (s_rdata)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    int cyc = 0;
    int strobe_cyc = -1;
    int ack_cyc = -1;
    int idle_cyc = 0;
    int slave_due = -1;
    int ptr = 0;
    int grant = 0;
    bit rst_eff = 1'b0;
    bit rst_next = 1'b0;
    bit exp_rw;
    logic [AW-1:0] exp_addr;
    logic [DW-1:0] exp_wdata;
    logic [DW-1:0] exp_rdata;
    logic [DW-1:0] slave_data;
    logic [DW-1:0] ref_mem [16];
    logic [DW-1:0] smem [16];
    int act_mask = 0;
    int p_req = 0;
    int glog [$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    function automatic int pick(input logic [N-1:0] r, input int p);
        for (int k = 0; k < N; k++) begin
            if (r[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    task automatic step();
        logic [N-1:0] exp_ack;
        @(negedge clk);
        cyc++;
        exp_ack = '0;
        if (!rst_eff) begin
            check("rst_ack", 64'(m_ack), 64'(0));
            check("rst_strobe", 64'(s_strobe), 64'(0));
            check("rst_rw", 64'(s_rw), 64'(0));
            check("rst_addr", 64'(s_addr), 64'(0));
            check("rst_wdata", 64'(s_wdata), 64'(0));
            check("rst_rdata", 64'(m_rdata), 64'(0));
        end else begin
            if (cyc == ack_cyc) exp_ack = N'(1) << grant;
            check("s_strobe", 64'(s_strobe), 64'(cyc == strobe_cyc));
            check("m_ack", 64'(m_ack), 64'(exp_ack));
            if (cyc == strobe_cyc) begin
                check("s_addr", 64'(s_addr), 64'(exp_addr));
                check("s_rw", 64'(s_rw), 64'(exp_rw));
                if (exp_rw) check("s_wdata", 64'(s_wdata), 64'(exp_wdata));
            end
            if (cyc == ack_cyc && !exp_rw) check("m_rdata", 64'(m_rdata), 64'(exp_rdata));
        end
        check("m_wait", 64'(m_wait), 64'(m_req & ~exp_ack));
        for (int i = 0; i < N; i++) if (m_ack[i]) glog.push_back(i);

        // Slave model: writes land at the strobe, read data is valid LATENCY cycles later
        if (s_strobe) begin
            if (s_rw) smem[s_addr[5:2]] = s_wdata;
            else begin
                slave_due  = cyc + L;
                slave_data = smem[s_addr[5:2]];
            end
        end
        s_rdata = (cyc == slave_due) ? slave_data : $urandom;

        reset_n = rst_next;
        rst_eff = rst_next;
        if (!rst_next) begin
            strobe_cyc = -1;
            ack_cyc    = -1;
            idle_cyc   = cyc + 1;
            ptr        = 0;
        end

        for (int i = 0; i < N; i++) begin
            if (m_req[i] && !m_ack[i]) begin
                m_req[i] = 1'b1;
            end else if (act_mask[i] && ($urandom_range(99) < p_req)) begin
                m_req[i] = 1'b1;
                m_rw[i]  = 1'($urandom_range(1));
                m_addr[i*AW +: AW]  = $urandom & 32'h0000_0FFC;
                m_wdata[i*DW +: DW] = $urandom;
            end else begin
                m_req[i] = 1'b0;
            end
        end

        // Transaction-level timeline: sample at t, strobe t+1, ack t+L+2, free again t+L+3
        if (rst_next && cyc >= idle_cyc && m_req != '0) begin
            grant      = pick(m_req, ptr);
            exp_rw     = m_rw[grant];
            exp_addr   = m_addr[grant*AW +: AW];
            exp_wdata  = m_wdata[grant*DW +: DW];
            strobe_cyc = cyc + 1;
            ack_cyc    = cyc + L + 2;
            idle_cyc   = cyc + L + 3;
            ptr        = (grant + 1) % N;
            if (exp_rw) ref_mem[exp_addr[5:2]] = exp_wdata;
            else exp_rdata = ref_mem[exp_addr[5:2]];
        end
    endtask

    task automatic run(input int mask, input int p, input int n);
        act_mask = mask;
        p_req    = p;
        for (int k = 0; k < n; k++) step();
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin
            ref_mem[i] = $urandom;
            smem[i]    = ref_mem[i];
        end

        rst_next = 1'b0;
        run(7, 100, 4);
        rst_next = 1'b1;

        run(1, 30, 40);
        run(0, 0, 25);

        glog.delete();
        run(7, 100, 60);
        check("rot_count", 64'(glog.size() >= 6), 64'(1));
        for (int k = 1; k < glog.size(); k++) check("rotate", 64'(glog[k]), 64'((glog[k-1] + 1) % N));
        run(0, 0, 25);

        glog.delete();
        run(5, 100, 50);
        check("alt_count", 64'(glog.size() >= 6), 64'(1));
        for (int k = 1; k < glog.size(); k++) check("alt02", 64'(glog[k]), 64'((glog[k-1] == 0) ? 2 : 0));
        run(0, 0, 25);

        // Reset inside WAIT: the in-flight transaction must vanish and ptr restart at 0
        act_mask = 7;
        p_req    = 100;
        for (int k = 0; k < 4 * (L + 3); k++) step();
        for (int k = 0; k < 2 * (L + 3); k++) begin
            step();
            if (cyc == strobe_cyc && grant != 0) break;
        end
        check("rst_trigger", 64'(cyc == strobe_cyc), 64'(1));
        rst_next = 1'b0;
        step();
        step();
        step();
        glog.delete();
        rst_next = 1'b1;
        run(7, 100, 30);
        check("rst_first", 64'((glog.size() > 0) ? glog[0] : 99), 64'(0));
        run(0, 0, 25);

        run(7, 50, 600);
        run(0, 0, 25);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Shares one single-port synchronous data memory between NMASTERS requesters, e.g. core data port, debug/loader port and DMA, using round-robin arbitration.
Each master uses a level req and a one-cycle ack handshake.
A per-master wait output lets a requester stall, for example by feeding the core halt bus, until its access completes.
The block sits between the masters and the memory/device bus and issues at most one memory transaction at a time.

Parameters:
NMASTERS, 2, number of requesters (2..8)
AW, 32, address width
DW, 32, data width
LATENCY, 1, cycles from slave strobe to valid s_rdata (>=1; 0 is illegal, simulation $error)

Ports:
clk  in  1  clock, all state updates on posedge
reset_n  in  1  synchronous, active-low reset
m_req  in  NMASTERS  per-master request, level
m_rw  in  NMASTERS  per-master 1=write 0=read
m_addr  in  NMASTERS*AW  flattened addresses, master i at [i*AW +: AW]
m_wdata  in  NMASTERS*DW  flattened write data
m_ack  out  NMASTERS  one-cycle completion pulse, one-hot or zero
m_wait  out  NMASTERS  m_req[i] & ~m_ack[i]; stall indication
m_rdata  out  DW  shared read-data bus, valid in the cycle m_ack is high
s_strobe  out  1  slave access strobe, one cycle per transaction
s_rw  out  1  slave write enable, qualified by s_strobe
s_addr  out  AW  slave address
s_wdata  out  DW  slave write data
s_rdata  in  DW  slave read data

Behaviour:
- Reset (reset_n low at posedge):
  - state IDLE, rr pointer 0, grant index 0.
  - m_ack 0, s_strobe 0, s_rw 0, m_rdata 0, latched addr/wdata 0.
  - Latency counter 0.
- Reset asserted mid-transaction aborts it: no ack is issued and the master must re-request.
- Master rule:
  - Hold req, rw, addr and wdata stable from req rise until the ack cycle.
  - After ack, req may drop, or stay high to start a new transaction.
  - A new transaction's fields must be valid in the cycle after ack.
- States:
  - IDLE:
    - If any m_req is high, pick the winner: the first requester at index >= ptr, searching upward with wrap.
    - Latch its index, rw, addr and wdata, then go to ISSUE.
    - Otherwise stay in IDLE.
  - ISSUE:
    - s_strobe=1 for exactly one cycle; s_rw/s_addr/s_wdata come from the latched registers.
    - Load counter = LATENCY-1, then go to WAIT.
  - WAIT:
    - Decrement the counter each cycle.
    - When the counter is 0: register m_rdata <= s_rdata (for writes too; the value is don't-care) and set m_ack[grant]=1 for the next cycle.
    - Set ptr <= (grant+1) mod NMASTERS, then go to RESP.
  - RESP: m_ack is high this cycle, m_rdata is valid; go to IDLE.
- Latency: req sampled in IDLE at cycle t; s_strobe at t+1; ack at t+LATENCY+2.
  - Back-to-back throughput is one transaction per LATENCY+3 cycles.
  - The IDLE cycle after RESP re-arbitrates.
- s_addr/s_wdata/s_rw hold their latched values outside ISSUE; only s_strobe qualifies them.
- Fairness:
  - With all masters requesting continuously, grants rotate 0,1,...,N-1,0.
  - No master waits more than N-1 transactions.
- A req dropped before ack (protocol violation) does not abort the transaction; ack is still pulsed.
- A req rising in the same cycle another master is granted waits for the next IDLE.
- ptr wraps from NMASTERS-1 to 0; for non-power-of-2 NMASTERS the wrap is by compare, not by bit truncation.
- Exactly one bit of m_ack is high in RESP; m_ack is 0 in all other states.

Decomposition:
- Shared header (alongside common.vh):
  - State encodings IDLE=0, ISSUE=1, WAIT=2, RESP=3.
  - Master index width macro clog2(NMASTERS).
- Sub-module rr_pick: combinational round-robin priority selector.
  - Inputs: req vector, ptr.
  - Outputs: winner index, any.
  - Instantiated once in mem_arbiter.

Test Plan:
1. Reset, then hold reset_n=0 for 3 cycles with m_req=2'b11 -> all outputs 0, no s_strobe.
2. Single read: LATENCY=1, master 0 reads 0x100, slave returns 0xDEADBEEF -> s_strobe at t+1 with s_addr=0x100, s_rw=0; m_ack=2'b01 at t+3 with m_rdata=0xDEADBEEF.
3. Both masters request continuously, master 1 writing 0x55 to 0x20 and master 0 reading 0x10 -> grants alternate 0,1,0,1; master 1 write shows s_rw=1, s_wdata=0x55; no master gets two consecutive acks.
4. LATENCY=3, master 1 single read -> ack exactly 5 cycles after req sampled; m_wait[1] high from req until the ack cycle, then 0.
5. Reset asserted during WAIT of a master 0 transaction -> no m_ack pulse; after release, master 0 re-requests 0x40 and completes normally, with ptr restarting at 0.
6. NMASTERS=3 with only masters 0 and 2 requesting -> grant order 0,2,0,2; ptr wraps 2->0 correctly.
